// File: rtl/regfile_bist_ctrl.sv
// regfile_bist_ctrl
// Self-test controller that drives an external register file and checks it.
// A run is two passes: the first uses the seed pattern, the second uses its
// bitwise inverse. Each pass writes every address in order, then reads every
// address back and compares against the value that was written.
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous reset, active-high
//   start      level request; only looked at while idle
//   rf_we      register file write enable (registered)
//   rf_addr    register file address (registered)
//   rf_wd      register file write data (registered)
//   rf_rd      register file read data, combinational from rf_addr
//   busy       high while writing or reading
//   done       one-cycle pulse when a run finishes
//   pass       last run had no mismatches
//   err_count  number of mismatches in the last run
//   fail_addr  address of the first mismatch in the last run
module regfile_bist_ctrl #(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 2,
  parameter int unsigned SEED = 4'hA
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_addr,
  output logic [DATA_W-1:0] rf_wd,
  input  logic [DATA_W-1:0] rf_rd,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ADDR_W+1:0] err_count,
  output logic [ADDR_W-1:0] fail_addr
);

  localparam int ERR_W = ADDR_W + 2;
  localparam logic [DATA_W-1:0] SEED_V = SEED[DATA_W-1:0];
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  typedef enum logic [1:0] {IDLE, WRITE, READ, DONE} state_t;

  state_t state;
  logic   pass_idx;
  logic   mismatch;

  // Value stored at address a during pass p: seed plus address, inverted on
  // the second pass so every bit gets exercised at both polarities.
  function automatic logic [DATA_W-1:0] exp_val(input logic [ADDR_W-1:0] a,
                                                input logic p);
    logic [DATA_W-1:0] v;
    v = SEED_V + DATA_W'(a);
    return v ^ {DATA_W{p}};
  endfunction

  // The register file reads combinationally, so the data for the address we
  // are presenting this cycle is already on rf_rd. The result only feeds the
  // registered counters below, so it never reaches the rf_* outputs.
  assign mismatch = (state == READ) && (rf_rd != exp_val(rf_addr, pass_idx));

  // Single sequencer. rf_addr doubles as the address counter; it wraps
  // naturally at the end of each phase, and that wrap is where the phase
  // changes. Every output is assigned here so all of them are registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      pass_idx  <= 1'b0;
      rf_we     <= 1'b0;
      rf_addr   <= '0;
      rf_wd     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_count <= '0;
      fail_addr <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state     <= WRITE;
            pass_idx  <= 1'b0;
            rf_we     <= 1'b1;
            rf_addr   <= '0;
            rf_wd     <= exp_val('0, 1'b0);
            busy      <= 1'b1;
            pass      <= 1'b0;
            err_count <= '0;
            fail_addr <= '0;
          end
        end
        WRITE: begin
          rf_addr <= rf_addr + ADDR_W'(1);
          if (rf_addr == LAST_ADDR) begin
            state <= READ;
            rf_we <= 1'b0;
            rf_wd <= '0;
          end else begin
            rf_wd <= exp_val(rf_addr + ADDR_W'(1), pass_idx);
          end
        end
        READ: begin
          if (mismatch) begin
            err_count <= err_count + ERR_W'(1);
            if (err_count == '0) fail_addr <= rf_addr;
          end
          rf_addr <= rf_addr + ADDR_W'(1);
          if (rf_addr == LAST_ADDR) begin
            if (!pass_idx) begin
              state    <= WRITE;
              pass_idx <= 1'b1;
              rf_we    <= 1'b1;
              rf_wd    <= exp_val('0, 1'b1);
            end else begin
              // The final read's compare is folded in directly because its
              // increment of err_count lands on this same edge.
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= (err_count == '0) && !mismatch;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_bist_ctrl.sv
// tb_regfile_bist_ctrl
// Drives regfile_bist_ctrl against a small behavioural 4x4 register file with
// an optional stuck-at fault mask on the read path. A reference model tracks
// the run by its position in the write/read schedule and predicts every output
// cycle by cycle; directed scenarios pin the model with literal values.
module tb_regfile_bist_ctrl;

  localparam int N = 4;
  localparam int RUN = 4 * N;
  localparam int SEED_N = 10;

  logic       clk;
  logic       rst;
  logic       start;
  logic       rf_we;
  logic [1:0] rf_addr;
  logic [3:0] rf_wd;
  logic [3:0] rf_rd;
  logic       busy;
  logic       done;
  logic       pass;
  logic [3:0] err_count;
  logic [1:0] fail_addr;

  logic [3:0] mem [4];
  logic [3:0] faultMask;

  int compared = 0;
  int mismatched = 0;
  bit checkOn = 0;

  int writeLog[$];
  int busyCycles = 0;
  int doneCount = 0;

  // Model state: pos is -1 when idle, 0..RUN-1 for the busy schedule slot,
  // RUN for the completion cycle.
  int pos = -1;
  int mPass = 0;
  int mErr = 0;
  int mFail = 0;

  regfile_bist_ctrl dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .rf_we(rf_we),
    .rf_addr(rf_addr),
    .rf_wd(rf_wd),
    .rf_rd(rf_rd),
    .busy(busy),
    .done(done),
    .pass(pass),
    .err_count(err_count),
    .fail_addr(fail_addr)
  );

  // 10-unit clock period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural register file: synchronous write, asynchronous read, with the
  // fault mask forcing selected data bits low on the way out.
  always @(posedge clk) begin
    if (rf_we) mem[rf_addr] <= rf_wd;
  end
  assign rf_rd = mem[rf_addr] & faultMask;

  // Pattern value for address a in pass p, straight from the pattern rule.
  function automatic int expVal(int a, int p);
    int v;
    v = (SEED_N + a) % 16;
    return p ? 15 - v : v;
  endfunction

  // A read slot fails when the faulty file cannot return the pattern value.
  function automatic bit readBad(int slot);
    int e;
    e = expVal(slot % N, slot / (2 * N));
    return (e & int'(faultMask)) != e;
  endfunction

  // Reference model advanced on the same edges as the design.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      pos = -1;
      mPass = 0;
      mErr = 0;
      mFail = 0;
    end else if (pos == -1) begin
      if (start) begin
        pos = 0;
        mPass = 0;
        mErr = 0;
        mFail = 0;
      end
    end else if (pos == RUN) begin
      pos = -1;
    end else begin
      if (((pos / N) % 2 == 1) && readBad(pos)) begin
        if (mErr == 0) mFail = pos % N;
        mErr = mErr + 1;
      end
      pos = pos + 1;
      if (pos == RUN) mPass = (mErr == 0) ? 1 : 0;
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    compared = compared + 1;
    if (actual !== expected) begin
      mismatched = mismatched + 1;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // One cycle of stimulus, applied well after the rising edge.
  task automatic applyStimulus(input logic s, input logic r);
    @(posedge clk);
    #2;
    start = s;
    rst = r;
  endtask

  task automatic waitDone(input int maxCycles);
    bit seen;
    seen = 0;
    for (int i = 0; i < maxCycles && !seen; i++) begin
      @(negedge clk);
      seen = done;
    end
    checkOutput("done_seen", int'(seen), 1);
  endtask

  // Activity trackers sampled on the falling edge.
  always @(negedge clk) begin
    if (rf_we) writeLog.push_back(int'(rf_wd));
    if (busy) busyCycles = busyCycles + 1;
    if (done) doneCount = doneCount + 1;
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    int eWe, eBusy, eDone, eAddr, eWd;
    if (checkOn) begin
      eWe = 0; eBusy = 0; eDone = 0; eAddr = 0; eWd = 0;
      if (pos >= 0 && pos < RUN) begin
        eBusy = 1;
        eAddr = pos % N;
        eWe = ((pos / N) % 2 == 0) ? 1 : 0;
        if (eWe == 1) eWd = expVal(pos % N, pos / (2 * N));
      end else if (pos == RUN) begin
        eDone = 1;
      end
      checkOutput("rf_we", int'(rf_we), eWe);
      checkOutput("rf_addr", int'(rf_addr), eAddr);
      if (eWe == 1 || eBusy == 0) checkOutput("rf_wd", int'(rf_wd), eWd);
      checkOutput("busy", int'(busy), eBusy);
      checkOutput("done", int'(done), eDone);
      checkOutput("pass", int'(pass), mPass);
      checkOutput("err_count", int'(err_count), mErr);
      checkOutput("fail_addr", int'(fail_addr), mFail);
    end
  end

  // Directed scenarios followed by randomized runs.
  initial begin
    int expWrites[8];
    int nCheck;
    expWrites = '{10, 11, 12, 13, 5, 4, 3, 2};
    rst = 1'b1;
    start = 1'b0;
    faultMask = 4'hF;

    // Reset state.
    @(negedge clk);
    checkOn = 1;
    checkOutput("reset_rf_we", int'(rf_we), 0);
    checkOutput("reset_busy", int'(busy), 0);
    checkOutput("reset_err", int'(err_count), 0);
    checkOutput("reset_pass", int'(pass), 0);
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0);

    // Fault-free run: write sequence and results pinned literally.
    writeLog.delete();
    busyCycles = 0;
    doneCount = 0;
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0);
    waitDone(30);
    checkOutput("clean_pass", int'(pass), 1);
    checkOutput("clean_err", int'(err_count), 0);
    checkOutput("clean_busy_len", busyCycles, 16);
    checkOutput("clean_writes", writeLog.size(), 8);
    nCheck = (writeLog.size() < 8) ? writeLog.size() : 8;
    for (int i = 0; i < nCheck; i++) checkOutput("write_value", writeLog[i], expWrites[i]);
    repeat (3) @(negedge clk);
    checkOutput("clean_done_pulses", doneCount, 1);

    // Data bit 0 stuck at 0.
    faultMask = 4'hE;
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0);
    waitDone(30);
    checkOutput("stuck_err", int'(err_count), 4);
    checkOutput("stuck_fail_addr", int'(fail_addr), 1);
    checkOutput("stuck_pass", int'(pass), 0);
    faultMask = 4'hF;
    repeat (2) applyStimulus(1'b0, 1'b0);

    // Second start pulse in cycle 5 of a run is ignored.
    busyCycles = 0;
    doneCount = 0;
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0);
    repeat (3) applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0);
    waitDone(30);
    checkOutput("restart_busy_len", busyCycles, 16);
    repeat (3) @(negedge clk);
    checkOutput("restart_idle_after", int'(busy), 0);
    checkOutput("restart_done_pulses", doneCount, 1);

    // Reset during the first read phase.
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0);
    repeat (4) applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1);
    #1;
    checkOutput("abort_rf_we", int'(rf_we), 0);
    checkOutput("abort_busy", int'(busy), 0);
    checkOutput("abort_rf_addr", int'(rf_addr), 0);
    writeLog.delete();
    applyStimulus(1'b0, 1'b1);
    repeat (4) applyStimulus(1'b0, 1'b0);
    checkOutput("abort_no_writes", writeLog.size(), 0);
    busyCycles = 0;
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0);
    waitDone(30);
    checkOutput("after_abort_pass", int'(pass), 1);
    checkOutput("after_abort_busy_len", busyCycles, 16);

    // Start held high: done, one idle cycle, then a fresh run.
    faultMask = 4'hE;
    applyStimulus(1'b1, 1'b0);
    waitDone(30);
    faultMask = 4'hF;
    @(negedge clk);
    checkOutput("held_idle_busy", int'(busy), 0);
    checkOutput("held_idle_err", int'(err_count), 4);
    @(negedge clk);
    checkOutput("held_rerun_busy", int'(busy), 1);
    checkOutput("held_rerun_err", int'(err_count), 0);
    checkOutput("held_rerun_fail", int'(fail_addr), 0);
    checkOutput("held_rerun_pass", int'(pass), 0);
    applyStimulus(1'b0, 1'b0);
    waitDone(30);
    checkOutput("held_second_pass", int'(pass), 1);

    // Randomized runs with random faults and occasional mid-run resets.
    for (int it = 0; it < 16; it++) begin
      int sel, holdLen, rstAt;
      bit doRst;
      sel = $urandom_range(0, 2);
      faultMask = (sel == 0) ? 4'hF : (sel == 1) ? 4'hE : 4'($urandom_range(0, 15));
      repeat ($urandom_range(0, 3)) applyStimulus(1'b0, 1'b0);
      holdLen = $urandom_range(1, 3);
      doRst = ($urandom_range(0, 3) == 0);
      rstAt = $urandom_range(0, 17);
      for (int k = 0; k < holdLen; k++) applyStimulus(1'b1, 1'b0);
      for (int c = 0; c < 22; c++) applyStimulus(1'b0, (doRst && c == rstAt) ? 1'b1 : 1'b0);
    end

    repeat (2) applyStimulus(1'b0, 1'b0);
    checkOn = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
